seg_adder: RTL and testbench
============================

Name: seg_adder

Overview:
- Pipelined, parametrised successor to the combinational adder, for the picoNISC datapath and DSP path.
- Splits an n-bit add/subtract into SEG-bit carry segments, one segment per pipeline stage. This shortens the carry chain so the adder closes timing at wider n.
- Supports per-operation add/subtract, wrap or saturate mode, and NZCV-style flags.
- Uses a valid/ready handshake on input and output, so it can sit between the operand register file and the writeback stage.

Parameters:
- n, 8, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, segment width in bits. NSEG = n/SEG is both the stage count and the latency. SEG = n gives a single-stage registered adder.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- a  in  n  operand A, signed two's complement.
- b  in  n  operand B, signed two's complement.
- sub  in  1  1: compute a-b; 0: compute a+b.
- sat  in  1  1: saturate on signed overflow; 0: wrap.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- result  out  n  final sum or difference.
- carry  out  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  result == 0, after saturation.
- neg  out  1  result MSB, after saturation.

Behaviour:
- Reset is synchronous and active-high. While reset is high at a clk edge:
  - all stage valid bits clear, so out_valid = 0;
  - result, carry, ovf, zero and neg are 0;
  - in-flight beats are discarded with no output.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational. in_ready is 1 during reset-held cycles; any beats accepted then are cleared by the reset.
  - When adv = 0, every stage register holds, including the output.
- Stage 0, on accept:
  - bx = sub ? ~b : b; carry-in = sub.
  - Adds a[SEG-1:0] + bx[SEG-1:0] + carry-in. The result segment and carry are registered.
  - The upper a and bx bits, sub and sat travel along with the beat.
- Stage k (1..NSEG-1) adds segment k plus the carry from stage k-1. Lower result segments already computed pass through unchanged.
- Final stage, combinational before the output register:
  - c_msb_in = carry into bit n-1; c_out = carry out of bit n-1.
  - ovf = c_msb_in ^ c_out; carry = c_out.
  - If sat && ovf: result = a[n-1] ? most negative (1 followed by n-1 zeros) : most positive (0 followed by n-1 ones). Otherwise result = raw.
  - zero and neg are taken from the final result.
- Latency: a beat accepted at edge t shows out_valid = 1 after edge t+NSEG-1. NSEG = 1 means the output is registered at the accept edge.
- Throughput: 1 beat per cycle when out_ready is held at 1.
- Bubbles: when in_valid = 0 during advance, stage 0 loads valid = 0. Bubbles propagate; data in invalid stages is don't-care.
- Back-pressure: the output is held stable, with all fields frozen, while out_valid && !out_ready. No beat is lost or duplicated.
- Wrap-around: in wrap mode the result is the raw sum mod 2^n; flags are still reported.
- Simultaneous output handshake and input accept in the same cycle is legal and required for full throughput.
- Width rules: operands are treated as signed only for ovf and saturation. carry is an unsigned carry.

Decomposition:
- Package adder_pkg:
  - typedef for the per-beat stage payload struct: a/bx upper bits, partial result, carry, sub, sat, valid;
  - constants for saturation limits as functions of n.
- Sub-module seg_add_stage, parametrised by SEG:
  - inputs: a_seg, b_seg, cin;
  - outputs: sum_seg, cout, c_msb_in (carry into the segment MSB);
  - instantiated NSEG times via generate.

Test Plan (run at n=8, SEG=4 and at n=8, SEG=8):
- a=0x7F, b=0x01, sub=0, sat=0 -> result=0x80, ovf=1, carry=0, neg=1, zero=0. With sat=1 -> result=0x7F, ovf=1, neg=0.
- a=0x80, b=0x01, sub=1, sat=1 -> result=0x80, ovf=1, carry=1. With sat=0 -> result=0x7F, ovf=1.
- a=0x05, b=0x05, sub=1 -> result=0x00, zero=1, carry=1, ovf=0. a=0x0F, b=0x01, sub=0 -> result=0x10 (checks carry crossing a segment boundary).
- Stream 100 $random beats with random sub/sat, out_ready=1 -> 100 outputs in order, each matching a golden function. First out_valid appears NSEG cycles after the first accept; no gaps.
- Drive 0x7F+0x01 and 0x05-0x05 back-to-back, then hold out_ready=0 for 3 cycles -> in_ready=0 and result/flags stable throughout. After release, beats emerge in order with no loss or duplication.
- Accept 2 beats, assert reset for 1 cycle mid-pipeline -> out_valid=0, all outputs 0 on the next cycle; neither discarded beat ever appears.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and saturation limits for the segmented pipelined adder.
package adder_pkg;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned MAX_W = 64;

    // Control bits that travel with each beat from one stage to the next.
    typedef struct packed {
        logic valid;
        logic sat;
        logic carry;
    } stage_ctl_t;

    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        logic [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return (one << (w - 1)) - one;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        logic [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/seg_add_stage.sv
// One SEG-bit ripple segment; also exposes the carry into its MSB for overflow detection.
module seg_add_stage #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cin,
    output logic [SEG-1:0] sum_seg,
    output logic           cout,
    output logic           c_msb_in
);

    if (SEG == 1) begin : g_bit
        assign c_msb_in = cin;
        assign sum_seg  = a_seg ^ b_seg ^ cin;
    end else begin : g_wide
        // Low bits added one wider so the top bit is the carry into the MSB.
        logic [SEG-1:0] low;
        assign low      = {1'b0, a_seg[SEG-2:0]} + {1'b0, b_seg[SEG-2:0]} + {{(SEG-1){1'b0}}, cin};
        assign c_msb_in = low[SEG-1];
        assign sum_seg  = {a_seg[SEG-1] ^ b_seg[SEG-1] ^ c_msb_in, low[SEG-2:0]};
    end

    assign cout = (a_seg[SEG-1] & b_seg[SEG-1]) | (c_msb_in & (a_seg[SEG-1] ^ b_seg[SEG-1]));

endmodule

// File: rtl/seg_adder.sv
// Pipelined add/subtract with one carry segment per stage, optional saturation and NZCV-style flags.
module seg_adder
    import adder_pkg::*;
#(
    parameter int unsigned n   = 8,
    parameter int unsigned SEG = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         sub,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] result,
    output logic         carry,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int unsigned NSEG = n / SEG;
    localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(n);
    localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(n);
    localparam logic [n-1:0] SAT_MAX = SAT_MAX_FULL[n-1:0];
    localparam logic [n-1:0] SAT_MIN = SAT_MIN_FULL[n-1:0];

    logic       adv;
    logic [n-1:0] bx;
    stage_ctl_t head_ctl;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bx       = sub ? ~b : b;

    always_comb begin
        head_ctl       = '0;
        head_ctl.valid = in_valid;
        head_ctl.sat   = sat;
        head_ctl.carry = sub;
    end

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int unsigned LO  = gi * SEG;
        localparam int unsigned REM = n - LO;

        // Operand bits from this segment upward; bit 0 is the segment LSB.
        logic [REM-1:0]    src_a;
        logic [REM-1:0]    src_bx;
        stage_ctl_t        src_ctl;
        logic [LO+SEG-1:0] res_next;
        logic [SEG-1:0]    sum_seg;
        logic              cout;
        logic              c_msb_in;

        if (gi == 0) begin : g_head
            assign src_a    = a;
            assign src_bx   = bx;
            assign src_ctl  = head_ctl;
            assign res_next = sum_seg;
        end else begin : g_link
            assign src_a    = g_stage[gi-1].g_mid.a_reg;
            assign src_bx   = g_stage[gi-1].g_mid.bx_reg;
            assign src_ctl  = g_stage[gi-1].g_mid.ctl_reg;
            assign res_next = {sum_seg, g_stage[gi-1].g_mid.res_reg};
        end

        seg_add_stage #(.SEG(SEG)) u_seg (
            .a_seg    (src_a[SEG-1:0]),
            .b_seg    (src_bx[SEG-1:0]),
            .cin      (src_ctl.carry),
            .sum_seg  (sum_seg),
            .cout     (cout),
            .c_msb_in (c_msb_in)
        );

        if (gi < NSEG - 1) begin : g_mid
            logic [REM-SEG-1:0] a_reg;
            logic [REM-SEG-1:0] bx_reg;
            logic [LO+SEG-1:0]  res_reg;
            stage_ctl_t         ctl_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_reg   <= '0;
                    bx_reg  <= '0;
                    res_reg <= '0;
                    ctl_reg <= '0;
                end else if (adv) begin
                    a_reg         <= src_a[REM-1:SEG];
                    bx_reg        <= src_bx[REM-1:SEG];
                    res_reg       <= res_next;
                    ctl_reg.valid <= src_ctl.valid;
                    ctl_reg.sat   <= src_ctl.sat;
                    ctl_reg.carry <= cout;
                end
            end
        end else begin : g_last
            logic         ovf_next;
            logic [n-1:0] fin;

            // On overflow the true result has the sign of a, so a's MSB picks the rail.
            assign ovf_next = c_msb_in ^ cout;
            assign fin      = (src_ctl.sat && ovf_next) ? (src_a[SEG-1] ? SAT_MIN : SAT_MAX) : res_next;

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                    carry     <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                    neg       <= 1'b0;
                end else if (adv) begin
                    out_valid <= src_ctl.valid;
                    result    <= fin;
                    carry     <= cout;
                    ovf       <= ovf_next;
                    zero      <= (fin == '0);
                    neg       <= fin[n-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_adder.sv
// Drives a 2-stage (SEG=4) and a 1-stage (SEG=8) adder side by side against an integer reference model.
module tb_seg_adder;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, out_ready, sub, sat;
    logic [N-1:0] a, b;

    logic in_ready4, out_valid4, carry4, ovf4, zero4, neg4;
    logic [N-1:0] result4;
    logic in_ready8, out_valid8, carry8, ovf8, zero8, neg8;
    logic [N-1:0] result8;

    always #5 clk = ~clk;

    seg_adder #(.n(N), .SEG(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .carry(carry4), .ovf(ovf4), .zero(zero4), .neg(neg4)
    );

    seg_adder #(.n(N), .SEG(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
        .carry(carry8), .ovf(ovf8), .zero(zero8), .neg(neg8)
    );

    typedef struct packed {
        logic [N-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         ng;
    } flags_t;

    typedef struct {
        flags_t f;
        int     edge_n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   outs0 = 0;
    int   outs1 = 0;
    bit   lat_check = 1'b0;

    // Reference: exact integer arithmetic, then range tests for overflow and carry.
    function automatic flags_t golden(input logic [N-1:0] ai, input logic [N-1:0] bi,
                                      input logic si, input logic sti);
        int sa, sb, ua, ub, sr;
        flags_t f;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        ua = int'(ai);
        ub = int'(bi);
        sr = si ? sa - sb : sa + sb;
        f.v = (sr > (2 ** (N - 1)) - 1) || (sr < -(2 ** (N - 1)));
        f.c = si ? (ua >= ub) : (ua + ub > (2 ** N) - 1);
        if (sti && f.v)
            f.res = (sr > 0) ? 8'h7F : 8'h80;
        else
            f.res = sr[N-1:0];
        f.z  = (f.res == '0);
        f.ng = f.res[N-1];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            errors++;
            $error("FAIL %s got=%h required=%h", tag, got, req);
        end
    endtask

    // Evaluated at negedge: describes the handshakes the next rising edge will perform.
    task automatic mon_step(input int id, input logic ov, input logic ir,
                            input flags_t got, input int nseg);
        exp_t e;
        bit   have;
        if (ov && out_ready) begin
            have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
            checks++;
            assert (have) else begin
                errors++;
                $error("FAIL out_unexpected dut%0d got=%h required=none", id, got);
            end
            if (have) begin
                if (id == 0) begin
                    e = q0.pop_front();
                    outs0++;
                end else begin
                    e = q1.pop_front();
                    outs1++;
                end
                checks++;
                assert (got === e.f) else begin
                    errors++;
                    $error("FAIL out_data dut%0d got=%h required=%h", id, got, e.f);
                end
                $display("dut%0d beat out %h expect %h", id, got, e.f);
                if (lat_check) begin
                    checks++;
                    assert (cyc + 1 - e.edge_n == nseg) else begin
                        errors++;
                        $error("FAIL latency dut%0d got=%0d required=%0d", id, cyc + 1 - e.edge_n, nseg);
                    end
                end
            end
        end
        if (in_valid && ir) begin
            e.f      = golden(a, b, sub, sat);
            e.edge_n = cyc + 1;
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            mon_step(0, out_valid4, in_ready4, {result4, carry4, ovf4, zero4, neg4}, 2);
            mon_step(1, out_valid8, in_ready8, {result8, carry8, ovf8, zero8, neg8}, 1);
        end
    end

    // Single beat held at the output with out_ready low, compared against the stated values.
    task automatic directed(input string tag, input logic [N-1:0] ai, input logic [N-1:0] bi,
                            input logic si, input logic sti, input flags_t req);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = ai; b = bi; sub = si; sat = sti;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_v4"}, 32'(out_valid4), 32'd1);
        chk({tag, "_d4"}, 32'({result4, carry4, ovf4, zero4, neg4}), 32'(req));
        chk({tag, "_v8"}, 32'(out_valid8), 32'd1);
        chk({tag, "_d8"}, 32'({result8, carry8, ovf8, zero8, neg8}), 32'(req));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int     base0, base1;
    flags_t hold0, hold1;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out4", 32'({out_valid4, result4, carry4, ovf4, zero4, neg4}), 32'd0);
        chk("rst_out8", 32'({out_valid8, result8, carry8, ovf8, zero8, neg8}), 32'd0);
        chk("rst_rdy4", 32'(in_ready4), 32'd1);
        chk("rst_rdy8", 32'(in_ready8), 32'd1);

        // Stated corner cases: {result, carry, ovf, zero, neg}
        directed("7f_add_wrap", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
        directed("7f_add_sat",  8'h7F, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0});
        directed("80_sub_sat",  8'h80, 8'h01, 1'b1, 1'b1, {8'h80, 1'b1, 1'b1, 1'b0, 1'b1});
        directed("80_sub_wrap", 8'h80, 8'h01, 1'b1, 1'b0, {8'h7F, 1'b1, 1'b1, 1'b0, 1'b0});
        directed("05_sub_05",   8'h05, 8'h05, 1'b1, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        directed("0f_add_01",   8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0, 1'b0});

        // Back-to-back beats, then stall the output for three cycles.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        a = 8'h7F; b = 8'h01; sub = 1'b0; sat = 1'b0;
        @(posedge clk); #1;
        a = 8'h05; b = 8'h05; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        hold0 = golden(8'h7F, 8'h01, 1'b0, 1'b0);
        hold1 = golden(8'h05, 8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy4", 32'(in_ready4), 32'd0);
            chk("bp_rdy8", 32'(in_ready8), 32'd0);
            chk("bp_hold4", 32'({out_valid4, result4, carry4, ovf4, zero4, neg4}), 32'({1'b1, hold0}));
            chk("bp_hold8", 32'({out_valid8, result8, carry8, ovf8, zero8, neg8}), 32'({1'b1, hold1}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_drain4", 32'(q0.size()), 32'd0);
        chk("bp_drain8", 32'(q1.size()), 32'd0);

        // Full-rate random stream: fixed latency, no gaps.
        @(posedge clk); #1;
        base0 = outs0; base1 = outs1;
        lat_check = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 lat_check = 1'b0;
        chk("stream_cnt4", 32'(outs0 - base0), 32'd100);
        chk("stream_cnt8", 32'(outs1 - base1), 32'd100);

        // Random valid and back-pressure.
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rand_drain4", 32'(q0.size()), 32'd0);
        chk("rand_drain8", 32'(q1.size()), 32'd0);

        // Reset with beats in flight: they must never emerge.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'h12; b = 8'h34; sub = 1'b0; sat = 1'b0;
        @(posedge clk); #1;
        a = 8'h56; b = 8'h21; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst4", 32'({out_valid4, result4, carry4, ovf4, zero4, neg4}), 32'd0);
        chk("mid_rst8", 32'({out_valid8, result8, carry8, ovf8, zero8, neg8}), 32'd0);
        base0 = outs0; base1 = outs1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_none4", 32'(outs0 - base0), 32'd0);
        chk("mid_rst_none8", 32'(outs1 - base1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
